// File: rtl/mandelbrot_pkg.sv
// -----------------------------------------------------------------------------
// mandelbrot_pkg
// Shared constants and types for the Mandelbrot engine and its pixel
// transmitter. Frame geometry and pixel width match the engine's counters.
//
// Contents:
//   H_PIXELS, V_LINES   default frame geometry
//   PIX_BITS            width of one iteration-count pixel
//   X_BITS, Y_BITS      widths of the raster position counters
//   BYTE_W, ENTRY_W     packed byte width and FIFO entry width
//   byte_entry_t        FIFO entry {eol, sof, data}
//   pack_pixels()       places the odd-x pixel above the even-x pixel
// -----------------------------------------------------------------------------
package mandelbrot_pkg;

    localparam int H_PIXELS = 640;
    localparam int V_LINES  = 480;
    localparam int PIX_BITS = 4;
    localparam int X_BITS   = 10;
    localparam int Y_BITS   = 9;

    localparam int BYTE_W   = 2 * PIX_BITS;
    localparam int ENTRY_W  = BYTE_W + 2;

    typedef struct packed {
        logic              eol;
        logic              sof;
        logic [BYTE_W-1:0] data;
    } byte_entry_t;

    // Byte layout: low nibble is the even-x pixel, high nibble the odd-x pixel.
    function automatic logic [BYTE_W-1:0] pack_pixels(
        input logic [PIX_BITS-1:0] odd_pix,
        input logic [PIX_BITS-1:0] even_pix
    );
        return {odd_pix, even_pix};
    endfunction

endpackage

// File: rtl/mandelbrot_pixel_tx_if.sv
// -----------------------------------------------------------------------------
// mandelbrot_pixel_tx_if
// Byte stream produced by the pixel transmitter, valid/ready handshake.
//
// Signals:
//   out_data   [7:0] packed pixels: [3:0] even-x pixel, [7:4] odd-x pixel
//   out_sof          byte holds pixels x=0,1 of line 0
//   out_eol          byte holds the last two pixels of a line
//   out_valid        a byte is presented
//   out_ready        sink accepts; transfer when out_valid & out_ready
//
// Modports: master = transmitter side, slave = sink side.
// -----------------------------------------------------------------------------
interface mandelbrot_pixel_tx_if;
    import mandelbrot_pkg::*;

    logic [BYTE_W-1:0] out_data;
    logic              out_sof;
    logic              out_eol;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output out_data,
        output out_sof,
        output out_eol,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_sof,
        input  out_eol,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/mandelbrot_byte_fifo.sv
// -----------------------------------------------------------------------------
// mandelbrot_byte_fifo
// Synchronous first-word-fall-through FIFO. The head entry is visible on
// pop_data whenever empty is low; after the FIFO drains, pop_data keeps the
// last entry that was popped (zero after reset).
//
// Parameters:
//   DATA_W   entry width
//   DEPTH    number of entries, power of 2, >= 2
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data   write request and entry; ignored when full unless a pop
//                     happens in the same cycle
//   pop               read request; ignored when empty
//   pop_data          head entry (or last popped entry when empty)
//   full, empty       occupancy flags derived from the registered count
// -----------------------------------------------------------------------------
module mandelbrot_byte_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] last_q;
    logic              do_push;
    logic              do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A pop on a full FIFO frees the slot the simultaneous push writes into.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign pop_data = empty ? last_q : mem[rd_ptr];

    // Pointers are PTR_W bits wide, so the increments wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= mem[rd_ptr];
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; only entries between rd_ptr and wr_ptr are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mandelbrot_pixel_tx.sv
// -----------------------------------------------------------------------------
// mandelbrot_pixel_tx
// Receive end of the Mandelbrot engine pixel stream. Tracks the raster
// position of incoming 4-bit iteration counts, packs two pixels per byte,
// buffers the bytes in a small FIFO and sends them on a valid/ready stream.
// The engine cannot be stalled, so bytes that find the FIFO full are dropped
// and a sticky overflow flag is raised instead of back-pressuring.
//
// Parameters:
//   H_PIXELS    pixels per line (even)
//   V_LINES     lines per frame
//   FIFO_DEPTH  byte entries (power of 2, >= 2)
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   frame_start      pulse: restart at x=0, y=0 (FIFO contents still drain)
//   pix_valid        one-cycle strobe, one pixel
//   pix_data  [3:0]  iteration count of that pixel
//   tx               byte stream (master): out_data/out_sof/out_eol/
//                    out_valid out, out_ready in
//   x_pos     [9:0]  x of next expected pixel
//   y_pos     [8:0]  y of next expected pixel
//   frame_done       one-cycle pulse after the last pixel of a frame
//   overflow         sticky: a byte was dropped
//   clear_overflow   clears overflow; a simultaneous drop wins
// -----------------------------------------------------------------------------
module mandelbrot_pixel_tx #(
    parameter int H_PIXELS   = mandelbrot_pkg::H_PIXELS,
    parameter int V_LINES    = mandelbrot_pkg::V_LINES,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              frame_start,
    input  logic                              pix_valid,
    input  logic [mandelbrot_pkg::PIX_BITS-1:0] pix_data,
    mandelbrot_pixel_tx_if.master             tx,
    output logic [mandelbrot_pkg::X_BITS-1:0]   x_pos,
    output logic [mandelbrot_pkg::Y_BITS-1:0]   y_pos,
    output logic                              frame_done,
    output logic                              overflow,
    input  logic                              clear_overflow
);

    import mandelbrot_pkg::*;

    logic [X_BITS-1:0]   x_cur;
    logic [Y_BITS-1:0]   y_cur;
    logic                x_last;
    logic                y_last;
    logic [PIX_BITS-1:0] nibble;
    logic                push;
    logic                drop;
    byte_entry_t         push_entry;
    byte_entry_t         head_entry;
    logic [ENTRY_W-1:0]  head_bits;
    logic                fifo_full;
    logic                fifo_empty;

    // frame_start takes effect before a pixel arriving in the same cycle, so
    // that pixel is placed at x=0, y=0.
    always_comb begin
        x_cur = frame_start ? '0 : x_pos;
        y_cur = frame_start ? '0 : y_pos;
    end

    assign x_last = (x_cur == X_BITS'(H_PIXELS - 1));
    assign y_last = (y_cur == Y_BITS'(V_LINES - 1));

    // Odd-x pixels complete a byte together with the nibble latched at even x.
    assign push = pix_valid && x_cur[0];

    always_comb begin
        push_entry.eol  = x_last;
        push_entry.sof  = (y_cur == '0) && (x_cur == X_BITS'(1));
        push_entry.data = pack_pixels(pix_data, nibble);
    end

    // A full FIFO only accepts a push when the sink pops in the same cycle
    // (full implies non-empty, so out_ready alone decides).
    assign drop = push && fifo_full && !tx.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_pos      <= '0;
            y_pos      <= '0;
            nibble     <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= pix_valid && x_last && y_last;
            overflow   <= drop || (overflow && !clear_overflow);

            if (pix_valid) begin
                // Position advances on every pixel, even when its byte is dropped.
                if (x_last) begin
                    x_pos <= '0;
                    y_pos <= y_last ? '0 : y_cur + 1'b1;
                end else begin
                    x_pos <= x_cur + 1'b1;
                    y_pos <= y_cur;
                end
                if (!x_cur[0]) begin
                    nibble <= pix_data;
                end
            end else if (frame_start) begin
                x_pos  <= '0;
                y_pos  <= '0;
                nibble <= '0;
            end
        end
    end

    mandelbrot_byte_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (tx.out_ready),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_entry   = byte_entry_t'(head_bits);
    assign tx.out_data  = head_entry.data;
    assign tx.out_sof   = head_entry.sof;
    assign tx.out_eol   = head_entry.eol;
    assign tx.out_valid = !fifo_empty;

endmodule

// File: tb/tb_mandelbrot_pixel_tx.sv
module tb_mandelbrot_pixel_tx;

    localparam int H     = 640;
    localparam int V     = 4;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic       pix_valid;
    logic [3:0] pix_data;
    logic [9:0] x_pos;
    logic [8:0] y_pos;
    logic       frame_done;
    logic       overflow;
    logic       clear_overflow;

    mandelbrot_pixel_tx_if tx();

    mandelbrot_pixel_tx #(
        .H_PIXELS   (H),
        .V_LINES    (V),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .frame_start    (frame_start),
        .pix_valid      (pix_valid),
        .pix_data       (pix_data),
        .tx             (tx),
        .x_pos          (x_pos),
        .y_pos          (y_pos),
        .frame_done     (frame_done),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: pixel index within the frame, pending even pixel,
    // bytes the sink is owed, and how many of them are still buffered.
    int          m_idx;
    logic [3:0]  m_nib;
    int          m_cnt;
    bit          m_ovf;
    logic [9:0]  exp_q[$];

    int          n_bytes = 0;
    int          n_sof   = 0;
    int          n_eol   = 0;
    int          n_fd    = 0;
    logic [9:0]  last_byte = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: each accepted byte is compared with the oldest owed byte.
    always @(negedge clk) begin
        if (!reset && tx.out_valid && tx.out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {tx.out_eol, tx.out_sof, tx.out_data}, -1);
            end else begin
                chk("byte", {tx.out_eol, tx.out_sof, tx.out_data}, exp_q.pop_front());
            end
            n_bytes++;
            if (tx.out_sof) n_sof++;
            if (tx.out_eol) n_eol++;
            last_byte = {tx.out_eol, tx.out_sof, tx.out_data};
        end
    end

    // One clock of stimulus; the model predicts the effect, then position,
    // overflow and frame_done are compared after the edge.
    task automatic step(input bit fs, input bit pv, input logic [3:0] pd,
                        input bit rdy, input bit clr);
        bit         pop;
        bit         push;
        bit         exp_fd;
        int         x;
        logic [9:0] b;
        frame_start    = fs;
        pix_valid      = pv;
        pix_data       = pd;
        tx.out_ready   = rdy;
        clear_overflow = clr;
        pop    = rdy && (m_cnt > 0);
        push   = 1'b0;
        exp_fd = 1'b0;
        b      = '0;
        if (fs) begin
            m_idx = 0;
            m_nib = '0;
        end
        if (pv) begin
            x = m_idx % H;
            if (x % 2 == 0) begin
                m_nib = pd;
            end else begin
                push = 1'b1;
                b = {(x == H - 1), (m_idx == 1), pd, m_nib};
            end
            m_idx++;
            if (m_idx == H * V) begin
                m_idx  = 0;
                exp_fd = 1'b1;
            end
        end
        if (clr) m_ovf = 1'b0;
        if (push) begin
            if (m_cnt == DEPTH && !pop) begin
                m_ovf = 1'b1;
            end else begin
                exp_q.push_back(b);
                m_cnt++;
            end
        end
        if (pop) m_cnt--;
        @(posedge clk);
        #1;
        if (frame_done) n_fd++;
        chk("x_pos", x_pos, m_idx % H);
        chk("y_pos", y_pos, m_idx / H);
        chk("overflow", overflow, m_ovf);
        chk("frame_done", frame_done, exp_fd);
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 4'h0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && (exp_q.size() != 0 || m_cnt != 0); i++) begin
            idle(1'b1);
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("drain_out_valid", tx.out_valid, 0);
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        frame_start    = 1'b0;
        pix_valid      = 1'b0;
        pix_data       = '0;
        tx.out_ready   = 1'b0;
        clear_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        m_idx = 0;
        m_nib = '0;
        m_cnt = 0;
        m_ovf = 1'b0;
        exp_q.delete();
        chk("rst_out_valid", tx.out_valid, 0);
        chk("rst_out_data", tx.out_data, 0);
        chk("rst_out_sof", tx.out_sof, 0);
        chk("rst_out_eol", tx.out_eol, 0);
        chk("rst_x_pos", x_pos, 0);
        chk("rst_y_pos", y_pos, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
    endtask

    initial begin
        int b0, e0, s0, fd0;

        do_reset();

        // Four pixels 1,2,3,4: bytes 0x21 (sof) and 0x43.
        b0 = n_bytes;
        step(1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd4, 1'b1, 1'b0);
        chk("first4_x_pos", x_pos, 4);
        drain();
        chk("first4_bytes", n_bytes - b0, 2);
        chk("first4_last_byte", last_byte, 10'h043);

        // One full line, data = x mod 16.
        b0 = n_bytes; e0 = n_eol;
        for (int x = 0; x < H; x++) begin
            step(x == 0, 1'b1, 4'(x % 16), 1'b1, 1'b0);
        end
        drain();
        chk("line_bytes", n_bytes - b0, H / 2);
        chk("line_eol", n_eol - e0, 1);
        chk("line_last_byte", last_byte, 10'h2FE);
        chk("line_y_pos", y_pos, 1);

        // Full frame, random data with idle gaps, sink always ready.
        b0 = n_bytes; e0 = n_eol; s0 = n_sof; fd0 = n_fd;
        step(1'b1, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        for (int p = 1; p < H * V; ) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1'b1);
            end else begin
                step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
                p++;
            end
        end
        drain();
        chk("frame_bytes", n_bytes - b0, H * V / 2);
        chk("frame_eol", n_eol - e0, V);
        chk("frame_sof", n_sof - s0, 1);
        chk("frame_done_count", n_fd - fd0, 1);
        chk("frame_overflow", overflow, 0);

        // Sink stalled for 20 pixels: 8 bytes held, the 9th and 10th dropped.
        b0 = n_bytes;
        for (int p = 0; p < 20; p++) begin
            step(p == 0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
        chk("stall_overflow", overflow, 1);
        drain();
        chk("stall_bytes", n_bytes - b0, DEPTH);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("stall_cleared", overflow, 0);

        // Full FIFO with push and pop together, then one push too many.
        for (int p = 0; p < 2 * DEPTH; p++) begin
            step(p == 0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b1, 1'b0);
        chk("pushpop_no_drop", overflow, 0);
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        chk("pushpop_then_full", overflow, 1);
        drain();
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        // frame_start at x=37 with bytes still queued.
        for (int p = 0; p < 37; p++) begin
            step(p == 0, 1'b1, 4'($urandom_range(0, 15)), p < 30, 1'b0);
        end
        chk("midline_x_pos", x_pos, 37);
        s0 = n_sof;
        step(1'b1, 1'b1, 4'd5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
        drain();
        chk("midline_last_byte", last_byte, 10'h165);
        chk("midline_sof", n_sof - s0, 1);

        // Random traffic: gaps, stalls, restarts and clears.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 2) != 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 49) == 0);
        end
        drain();

        // Reset mid-frame discards queued bytes and the pending nibble.
        for (int p = 0; p < 7; p++) begin
            step(1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b0);
        end
        do_reset();
        step(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'd10, 1'b1, 1'b0);
        drain();
        chk("post_reset_byte", last_byte, 10'h1A9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
